demux_word_collector: RTL and testbench

- Sits directly downstream of the 1-to-16 demultiplexer.
- Each demux output is treated as one serial channel. A bit is sampled from channel `sel` on every qualified input cycle, and 16 independent shift registers assemble the bits into WORD_W-bit words.
- Completed words go through a round-robin arbiter onto a single valid/ready output stream tagged with the channel number.
- Per-channel overflow is flagged when bits arrive for a channel whose completed word has not been drained.

---
 rtl/demux_word_collector.sv | 88 ++++++++
 tb/tb_demux_word_collector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_word_collector.sv
// demux_word_collector: assembles serial bits from 16 demux channels into words and streams them out round-robin
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid, sel     qualifies a bit sample from channel sel
//   din_bus           demux outputs, only din_bus[sel] is sampled
//   out_valid/ready   output handshake, out_chan tags out_word (first bit in MSB)
//   ovf_flags         sticky per-channel overflow, ovf_clr clears all (new overflow wins)
module demux_word_collector #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        sel,
    input  logic [15:0]       din_bus,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_chan,
    output logic [WORD_W-1:0] out_word,
    output logic [15:0]       ovf_flags,
    input  logic              ovf_clr
);
    localparam int CW = $clog2(WORD_W);

    logic [WORD_W-1:0] sh [16];
    logic [CW-1:0]     cnt [16];
    logic [15:0]       full;
    logic [15:0]       ovf_set;
    logic [3:0]        last_grant;
    logic [3:0]        g;
    logic [3:0]        idx;
    logic              hit;
    logic              free;
    logic              take;

    // Round-robin search: walking the offset downward lets the nearest
    // full channel after last_grant overwrite any farther hit.
    always_comb begin
        hit = 1'b0;
        g   = last_grant;
        idx = last_grant;
        for (int i = 16; i >= 1; i--) begin
            idx = last_grant + 4'(i);
            if (full[idx]) begin
                hit = 1'b1;
                g   = idx;
            end
        end
    end

    assign free    = !out_valid || out_ready;
    assign take    = free && hit;
    // A bit for a full channel is only dropped if that channel's word is not leaving this cycle.
    assign ovf_set = (in_valid && full[sel] && !(take && g == sel)) ? 16'd1 << sel : 16'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 16; c++) begin
                sh[c]  <= '0;
                cnt[c] <= '0;
            end
            full       <= '0;
            last_grant <= 4'd15;
            out_valid  <= 1'b0;
            out_chan   <= '0;
            out_word   <= '0;
            ovf_flags  <= '0;
        end else begin
            for (int c = 0; c < 16; c++) begin
                if (in_valid && sel == 4'(c) && (!full[c] || (take && g == 4'(c)))) begin
                    sh[c]  <= {sh[c][WORD_W-2:0], din_bus[c]};
                    cnt[c] <= full[c] ? CW'(1) : (cnt[c] == CW'(WORD_W - 1) ? '0 : cnt[c] + CW'(1));
                end
                full[c] <= (in_valid && sel == 4'(c) && !full[c]) ? cnt[c] == CW'(WORD_W - 1)
                                                                   : full[c] && !(take && g == 4'(c));
            end
            if (free) begin
                out_valid <= hit;
                if (hit) begin
                    out_word   <= sh[g];
                    out_chan   <= g;
                    last_grant <= g;
                end
            end
            ovf_flags <= (ovf_clr ? 16'd0 : ovf_flags) | ovf_set;
        end
    end
endmodule

// File: tb/tb_demux_word_collector.sv
// tb_demux_word_collector: directed and random checks of demux_word_collector against a queue-based model
module tb_demux_word_collector;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [3:0]    sel = '0;
    logic [15:0]   din_bus = '0;
    logic          out_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          out_valid;
    logic [3:0]    out_chan;
    logic [W-1:0]  out_word;
    logic [15:0]   ovf_flags;

    int checks = 0;
    int failures = 0;
    bit run = 0;

    // model: each channel collects bits in a queue; a full queue becomes a pending word
    bit          bq [16][$];
    bit          pend [16];
    int          pw [16];
    bit          m_valid;
    int          m_chan, m_word, m_last, gr;
    logic [15:0] m_ovf;
    bit          m_free, drop;

    always #5 clk = ~clk;

    demux_word_collector #(.WORD_W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sel(sel), .din_bus(din_bus),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
        .out_word(out_word), .ovf_flags(ovf_flags), .ovf_clr(ovf_clr)
    );

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 0; m_chan = 0; m_word = 0; m_ovf = '0; m_last = 15;
            for (int i = 0; i < 16; i++) begin
                bq[i].delete();
                pend[i] = 0;
                pw[i] = 0;
            end
        end else begin
            m_free = !m_valid || out_ready;
            gr = -1;
            if (m_free)
                for (int i = 1; i <= 16; i++)
                    if (gr < 0 && pend[(m_last + i) % 16]) gr = (m_last + i) % 16;
            drop = in_valid && pend[sel] && gr != int'(sel);
            if (ovf_clr) m_ovf = '0;
            if (drop) m_ovf[sel] = 1'b1;
            if (m_free) begin
                m_valid = gr >= 0;
                if (gr >= 0) begin
                    m_word = pw[gr];
                    m_chan = gr;
                    m_last = gr;
                    pend[gr] = 0;
                end
            end
            if (in_valid && !drop) begin
                bq[sel].push_back(din_bus[sel]);
                if (bq[sel].size() == W) begin
                    pw[sel] = 0;
                    foreach (bq[sel][k]) pw[sel] = (pw[sel] << 1) | int'(bq[sel][k]);
                    pend[sel] = 1;
                    bq[sel].delete();
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("model_out_valid", 32'(out_valid), 32'(m_valid));
            chk("model_out_chan", 32'(out_chan), 32'(m_chan));
            chk("model_out_word", 32'(out_word), 32'(m_word));
            chk("model_ovf_flags", 32'(ovf_flags), 32'(m_ovf));
        end
    end

    task automatic cyc(input bit v, input int s, input bit b, input bit rdy, input bit clr = 0, input bit r = 0);
        in_valid = v;
        sel = 4'(s);
        din_bus = 16'($urandom);
        din_bus[sel] = b;
        out_ready = rdy;
        ovf_clr = clr;
        rst = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic feed(input int ch, input logic [7:0] w, input bit rdy);
        for (int i = 7; i >= 0; i--) cyc(1, ch, w[i], rdy);
    endtask

    task automatic idle(input bit rdy, input int n = 1);
        for (int i = 0; i < n; i++) cyc(0, $urandom_range(0, 15), 1'($urandom_range(0, 1)), rdy);
    endtask

    task automatic out_is(input string n, input bit v, input int ch, input int w);
        chk({n, "_valid"}, 32'(out_valid), 32'(v));
        chk({n, "_chan"}, 32'(out_chan), 32'(ch));
        chk({n, "_word"}, 32'(out_word), 32'(w));
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 1);
        run = 1;
        out_is("reset", 0, 0, 0);
        chk("reset_ovf", 32'(ovf_flags), 0);

        feed(5, 8'hB2, 1);
        chk("t1_latency", 32'(out_valid), 0);
        idle(1);
        out_is("t1_word", 1, 5, 8'hB2);
        idle(1);
        chk("t1_single", 32'(out_valid), 0);

        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 7; i >= 0; i--) begin
            cyc(1, 3, 1'(8'hA5 >> i), 1);
            cyc(1, 12, 1'(8'h3C >> i), 1);
        end
        out_is("t2_first", 1, 3, 8'hA5);
        idle(1);
        out_is("t2_second", 1, 12, 8'h3C);

        cyc(0, 0, 0, 0, 0, 1);
        feed(0, 8'hFF, 0);
        idle(0);
        out_is("t3_load", 1, 0, 8'hFF);
        feed(0, 8'h81, 0);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        out_is("t3_hold", 1, 0, 8'hFF);
        chk("t3_ovf", 32'(ovf_flags), 32'h0001);
        cyc(1, 0, 1, 0, 1);
        chk("t3_set_wins", 32'(ovf_flags), 32'h0001);
        cyc(0, 0, 0, 0, 1);
        chk("t3_clr", 32'(ovf_flags), 0);
        idle(1);
        out_is("t3_next", 1, 0, 8'h81);
        idle(1);
        chk("t3_drain", 32'(out_valid), 0);

        cyc(0, 0, 0, 0, 0, 1);
        feed(7, 8'h5A, 1);
        cyc(1, 7, 1, 1);
        out_is("t4_grant", 1, 7, 8'h5A);
        chk("t4_no_ovf", 32'(ovf_flags), 0);
        for (int i = 6; i >= 0; i--) cyc(1, 7, 1'(8'hAA >> i), 1);
        chk("t4_pending", 32'(out_valid), 0);
        idle(1);
        out_is("t4_next", 1, 7, 8'hAA);

        cyc(0, 0, 0, 0, 0, 1);
        feed(1, 8'h11, 0);
        feed(2, 8'h22, 0);
        feed(9, 8'h99, 0);
        idle(0);
        out_is("t5_a", 1, 1, 8'h11);
        idle(1);
        out_is("t5_b", 1, 2, 8'h22);
        idle(0);
        out_is("t5_b_hold", 1, 2, 8'h22);
        idle(1);
        out_is("t5_c", 1, 9, 8'h99);
        idle(1);
        chk("t5_empty", 32'(out_valid), 0);

        cyc(0, 0, 0, 0, 0, 1);
        feed(6, 8'h6E, 0);
        idle(0);
        chk("t6_pending", 32'(out_valid), 1);
        for (int i = 0; i < 5; i++) cyc(1, 4, 1, 0);
        cyc(1, 4, 1, 1, 0, 1);
        out_is("t6_reset", 0, 0, 0);
        feed(4, 8'hC3, 1);
        idle(1);
        out_is("t6_fresh", 1, 4, 8'hC3);
        idle(1);
        chk("t6_once", 32'(out_valid), 0);

        for (int n = 0; n < 4000; n++) begin
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15),
                1'($urandom_range(0, 1)),
                (n / 200) % 2 == 0 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 4) == 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 599) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
